// File: rtl/atmega_tim_pkg.sv
// -----------------------------------------------------------------------------
// atmega_tim_pkg
// Shared constants for the ATmega-style timer blocks: register bit positions
// and the clock-select (CS) encoding used by the tick multiplexer.
// No ports (package).
// -----------------------------------------------------------------------------
package atmega_tim_pkg;

    // ICCR fields
    localparam int unsigned CS_W     = 3;
    localparam int unsigned ICES_BIT = 6;
    localparam int unsigned ICNC_BIT = 7;

    // TIMSK fields
    localparam int unsigned TOIE_BIT = 0;
    localparam int unsigned ICIE_BIT = 5;

    // TIFR fields
    localparam int unsigned TOV_BIT  = 0;
    localparam int unsigned ICF_BIT  = 5;

    // Clock-select encoding
    typedef enum logic [2:0] {
        CS_STOP    = 3'b000,
        CS_CLK1    = 3'b001,
        CS_CLK8    = 3'b010,
        CS_CLK64   = 3'b011,
        CS_CLK256  = 3'b100,
        CS_CLK1024 = 3'b101,
        CS_T_FALL  = 3'b110,
        CS_T_RISE  = 3'b111
    } cs_e;

endpackage

// File: rtl/atmega_icp_edge_filter.sv
// -----------------------------------------------------------------------------
// atmega_icp_edge_filter
// Two-flop synchroniser, optional 4-sample noise canceler and edge-select
// detector for an asynchronous pin. Used for the capture pin and, with the
// filter off, for the external count clock.
//
// Build option: ATMEGA_TIM_ICP_NOISE_CANCELER_EN adds the canceler and the
// filter_en port; without it the synchronised level feeds the detector.
//
// Ports:
//   clk_i      in  core clock
//   rst_i      in  asynchronous active-high reset
//   sig        in  asynchronous pin
//   filter_en  in  select filtered level (only with the build option)
//   edge_rise  in  1: rising edges qualify, 0: falling edges qualify
//   cap_stb    out one-cycle strobe on a qualified edge
// -----------------------------------------------------------------------------
module atmega_icp_edge_filter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig,
`ifdef ATMEGA_TIM_ICP_NOISE_CANCELER_EN
    input  logic filter_en,
`endif
    input  logic edge_rise,
    output logic cap_stb
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1   <= sig;
            sync2   <= sync1;
            level_q <= level;
        end
    end

`ifdef ATMEGA_TIM_ICP_NOISE_CANCELER_EN
    logic       filt;
    logic [1:0] run_cnt;

    // filt follows sync2 only after four consecutive differing samples;
    // it runs continuously so it is already settled when filter_en is set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt    <= 1'b0;
            run_cnt <= '0;
        end else if (sync2 == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == 2'd3) begin
            filt    <= sync2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 2'd1;
        end
    end

    always_comb level = filter_en ? filt : sync2;
`else
    always_comb level = sync2;
`endif

    // Compares successive levels only, so changing edge_rise never strobes.
    always_comb cap_stb = edge_rise ? (level & ~level_q) : (~level & level_q);

endmodule

// File: rtl/atmega_tim_icp_8bit.sv
// -----------------------------------------------------------------------------
// atmega_tim_icp_8bit
// 8-bit timer with input capture: free-running counter, capture register,
// overflow/capture flags and interrupt requests on the IO register bus.
//
// Build option: ATMEGA_TIM_ICP_NOISE_CANCELER_EN makes ICNC (ICCR[7])
// read/write and enables the capture-pin noise canceler; otherwise ICNC
// reads 0 and writes to it are dropped.
//
// Ports:
//   clk_i                         in  IO core clock
//   rst_i                         in  asynchronous active-high reset
//   clk8_i..clk1024_i             in  prescaler taps (synchronous)
//   addr_i, wr_i, rd_i, bus_i     in  register bus
//   bus_o                         out read data (combinational)
//   icp_i                         in  asynchronous capture pin
//   t_i                           in  asynchronous external count clock
//   icp_int_o, tov_int_o          out interrupt requests
//   icp_int_ack_i, tov_int_ack_i  in  interrupt acknowledges
// -----------------------------------------------------------------------------
module atmega_tim_icp_8bit
    import atmega_tim_pkg::*;
#(
    parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICCR_ADDR         = 'h81,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] TCNT_ADDR         = 'h84,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] ICR_ADDR          = 'h86,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] TIMSK_ADDR        = 'h6F,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] TIFR_ADDR         = 'h36
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clk8_i,
    input  logic                         clk64_i,
    input  logic                         clk256_i,
    input  logic                         clk1024_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_i,
    output logic [7:0]                   bus_o,
    input  logic                         icp_i,
    input  logic                         t_i,
    output logic                         icp_int_o,
    output logic                         tov_int_o,
    input  logic                         icp_int_ack_i,
    input  logic                         tov_int_ack_i
);

    cs_e        cs;
    logic       ices;
    logic       icnc;
    logic [7:0] tcnt;
    logic [7:0] icr;
    logic       toie;
    logic       icie;
    logic       tov;
    logic       icf;
    logic [3:0] tap_q;

    logic       wr_iccr, wr_tcnt, wr_timsk, wr_tifr;
    logic [3:0] tap_rise;
    logic       t_stb;
    logic       cap_stb;
    logic       tick;
    logic       tov_set, tov_clr, icf_clr;

    always_comb begin
        wr_iccr  = wr_i && (addr_i == ICCR_ADDR);
        wr_tcnt  = wr_i && (addr_i == TCNT_ADDR);
        wr_timsk = wr_i && (addr_i == TIMSK_ADDR);
        wr_tifr  = wr_i && (addr_i == TIFR_ADDR);
    end

    atmega_icp_edge_filter u_icp_filt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sig       (icp_i),
`ifdef ATMEGA_TIM_ICP_NOISE_CANCELER_EN
        .filter_en (icnc),
`endif
        .edge_rise (ices),
        .cap_stb   (cap_stb)
    );

    atmega_icp_edge_filter u_t_filt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sig       (t_i),
`ifdef ATMEGA_TIM_ICP_NOISE_CANCELER_EN
        .filter_en (1'b0),
`endif
        .edge_rise (cs[0]),
        .cap_stb   (t_stb)
    );

    // Each tap keeps its own history so switching CS cannot fake an edge.
    always_comb tap_rise = {clk1024_i, clk256_i, clk64_i, clk8_i} & ~tap_q;

    always_comb begin
        tick = 1'b0;
        case (cs)
            CS_STOP:               tick = 1'b0;
            CS_CLK1:               tick = 1'b1;
            CS_CLK8:               tick = tap_rise[0];
            CS_CLK64:              tick = tap_rise[1];
            CS_CLK256:             tick = tap_rise[2];
            CS_CLK1024:            tick = tap_rise[3];
            CS_T_FALL, CS_T_RISE:  tick = t_stb;
            default:               tick = 1'b0;
        endcase
    end

    // A bus write to TCNT suppresses the increment, hence also the overflow.
    always_comb begin
        tov_set = tick && (tcnt == 8'hFF) && !wr_tcnt;
        tov_clr = tov_int_ack_i || (wr_tifr && bus_i[TOV_BIT]);
        icf_clr = icp_int_ack_i || (wr_tifr && bus_i[ICF_BIT]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs    <= CS_STOP;
            ices  <= 1'b0;
            tcnt  <= '0;
            icr   <= '0;
            toie  <= 1'b0;
            icie  <= 1'b0;
            tov   <= 1'b0;
            icf   <= 1'b0;
            tap_q <= '0;
        end else begin
            tap_q <= {clk1024_i, clk256_i, clk64_i, clk8_i};
            if (wr_iccr) begin
                cs   <= cs_e'(bus_i[CS_W-1:0]);
                ices <= bus_i[ICES_BIT];
            end
            if (wr_tcnt) begin
                tcnt <= bus_i;
            end else if (tick) begin
                tcnt <= tcnt + 8'd1;
            end
            if (cap_stb) begin
                icr <= tcnt;
            end
            if (wr_timsk) begin
                toie <= bus_i[TOIE_BIT];
                icie <= bus_i[ICIE_BIT];
            end
            tov <= tov_set | (tov & ~tov_clr);
            icf <= cap_stb | (icf & ~icf_clr);
        end
    end

`ifdef ATMEGA_TIM_ICP_NOISE_CANCELER_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            icnc <= 1'b0;
        end else if (wr_iccr) begin
            icnc <= bus_i[ICNC_BIT];
        end
    end
`else
    always_comb icnc = 1'b0;
`endif

    always_comb begin
        icp_int_o = icf & icie;
        tov_int_o = tov & toie;
    end

    always_comb begin
        bus_o = '0;
        if (rd_i && !rst_i) begin
            case (addr_i)
                ICCR_ADDR: begin
                    bus_o[CS_W-1:0] = cs;
                    bus_o[ICES_BIT] = ices;
                    bus_o[ICNC_BIT] = icnc;
                end
                TCNT_ADDR:  bus_o = tcnt;
                ICR_ADDR:   bus_o = icr;
                TIMSK_ADDR: begin
                    bus_o[TOIE_BIT] = toie;
                    bus_o[ICIE_BIT] = icie;
                end
                TIFR_ADDR: begin
                    bus_o[TOV_BIT] = tov;
                    bus_o[ICF_BIT] = icf;
                end
                default: bus_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_atmega_tim_icp_8bit.sv
// -----------------------------------------------------------------------------
// tb_atmega_tim_icp_8bit
// Directed stimulus pushes expected values into a scoreboard queue; a monitor
// on the falling clock edge pops and compares whenever the bench asserts a
// read or interrupt probe.
// -----------------------------------------------------------------------------
module tb_atmega_tim_icp_8bit;

    localparam logic [7:0] A_ICCR  = 8'h81;
    localparam logic [7:0] A_TCNT  = 8'h84;
    localparam logic [7:0] A_ICR   = 8'h86;
    localparam logic [7:0] A_TIMSK = 8'h6F;
    localparam logic [7:0] A_TIFR  = 8'h36;

`ifdef ATMEGA_TIM_ICP_NOISE_CANCELER_EN
    localparam int unsigned CAP_LAT   = 7;
    localparam logic [7:0]  ICNC_VAL  = 8'h80;
    localparam logic [7:0]  ICCR_RB   = 8'hC0;
`else
    localparam int unsigned CAP_LAT   = 3;
    localparam logic [7:0]  ICNC_VAL  = 8'h00;
    localparam logic [7:0]  ICCR_RB   = 8'h40;
`endif

    logic       clk;
    logic       rst;
    logic       clk8, clk64, clk256, clk1024;
    logic [7:0] addr;
    logic       wr, rd;
    logic [7:0] wdata;
    logic [7:0] bus_o;
    logic       icp, t_in;
    logic       icp_int_o, tov_int_o;
    logic       icp_ack, tov_ack;

    atmega_tim_icp_8bit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clk8_i        (clk8),
        .clk64_i       (clk64),
        .clk256_i      (clk256),
        .clk1024_i     (clk1024),
        .addr_i        (addr),
        .wr_i          (wr),
        .rd_i          (rd),
        .bus_i         (wdata),
        .bus_o         (bus_o),
        .icp_i         (icp),
        .t_i           (t_in),
        .icp_int_o     (icp_int_o),
        .tov_int_o     (tov_int_o),
        .icp_int_ack_i (icp_ack),
        .tov_int_ack_i (tov_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] val;
        bit         irq;
    } exp_t;

    exp_t        sb[$];
    logic        mon_req;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always @(negedge clk) begin
        if (mon_req) begin : mon
            exp_t       e;
            logic [7:0] act;
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_empty: output presented with no expectation");
            end else begin
                e   = sb.pop_front();
                act = e.irq ? {6'b000000, icp_int_o, tov_int_o} : bus_o;
                if (act !== e.val) begin
                    n_errors++;
                    $display("FAIL %s: got %02h expected %02h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        step();
        wr    = 1'b0;
    endtask

    task automatic bus_chk(input logic [7:0] a, input logic r, input logic [7:0] v, input string nm);
        exp_t e;
        e.name = nm; e.val = v; e.irq = 1'b0;
        sb.push_back(e);
        addr    = a;
        rd      = r;
        mon_req = 1'b1;
        step();
        rd      = 1'b0;
        mon_req = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] v, input string nm);
        bus_chk(a, 1'b1, v, nm);
    endtask

    // v[1] = icp_int_o, v[0] = tov_int_o
    task automatic irq_chk(input logic [1:0] v, input string nm);
        exp_t e;
        e.name = nm; e.val = {6'b000000, v}; e.irq = 1'b1;
        sb.push_back(e);
        mon_req = 1'b1;
        step();
        mon_req = 1'b0;
    endtask

    // ICF must stay clear for lat sampled cycles, then appear.
    task automatic lat_chk(input int unsigned lat, input string nm);
        for (int unsigned i = 0; i < lat; i++) rd_chk(A_TIFR, 8'h00, nm);
        rd_chk(A_TIFR, 8'h20, nm);
    endtask

    initial begin
        rst = 1'b1;
        {clk8, clk64, clk256, clk1024} = '0;
        addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0;
        icp = 1'b0; t_in = 1'b0; icp_ack = 1'b0; tov_ack = 1'b0;
        mon_req = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        bus_chk(A_TIFR, 1'b1, 8'h00, "reset_bus");
        irq_chk(2'b00, "reset_irq");
        rst = 1'b0;
        rd_chk(A_ICCR,  8'h00, "reset_iccr");
        rd_chk(A_TCNT,  8'h00, "reset_tcnt");
        rd_chk(A_ICR,   8'h00, "reset_icr");
        rd_chk(A_TIMSK, 8'h00, "reset_timsk");
        rd_chk(A_TIFR,  8'h00, "reset_tifr");
        rd_chk(8'h00,   8'h00, "unmapped_read");

        // Rising capture with the counter running from 10
        wr_reg(A_ICCR, 8'h41);
        wr_reg(A_TCNT, 8'd10);
        icp = 1'b1;
        lat_chk(3, "cap_latency");
        rd_chk(A_ICR, 8'h0C, "cap_icr");
        wr_reg(A_ICCR, 8'h40);
        irq_chk(2'b00, "icp_masked");
        wr_reg(A_TIMSK, 8'h20);
        irq_chk(2'b10, "icp_irq");
        icp_ack = 1'b1; step(); icp_ack = 1'b0;
        irq_chk(2'b00, "icp_ack_irq");
        rd_chk(A_TIFR, 8'h00, "icp_ack_flag");

        // Overflow from FE; ICES change with icp high must not capture
        wr_reg(A_TIMSK, 8'h01);
        wr_reg(A_TCNT, 8'hFE);
        wr_reg(A_ICCR, 8'h01);
        rd_chk(A_TIFR, 8'h00, "tov_early0");
        rd_chk(A_TIFR, 8'h00, "tov_early1");
        rd_chk(A_TIFR, 8'h01, "tov_set");
        irq_chk(2'b01, "tov_irq");
        wr_reg(A_ICCR, 8'h00);
        tov_ack = 1'b1; step(); tov_ack = 1'b0;
        irq_chk(2'b00, "tov_ack_irq");
        rd_chk(A_TIFR, 8'h00, "tov_ack_flag");

        // Write FF wins over tick, following tick overflows
        wr_reg(A_ICCR, 8'h01);
        wr_reg(A_TCNT, 8'hFF);
        rd_chk(A_TIFR, 8'h00, "ffwr_no_tov");
        rd_chk(A_TIFR, 8'h01, "ffwr_tov");
        wr_reg(A_ICCR, 8'h00);
        rd_chk(A_TCNT, 8'h02, "tcnt_wrap");
        wr_reg(A_TIFR, 8'hFF);
        rd_chk(A_TIFR, 8'h00, "tifr_w1c");

        // Prescaler tap clk8: three rising edges
        wr_reg(A_TCNT, 8'h00);
        wr_reg(A_ICCR, 8'h02);
        for (int i = 0; i < 3; i++) begin
            clk8 = 1'b1; clk64 = ~clk64; step(); clk64 = ~clk64; step();
            clk8 = 1'b0; clk64 = ~clk64; step(); clk64 = ~clk64; step();
        end
        wr_reg(A_ICCR, 8'h00);
        rd_chk(A_TCNT, 8'h03, "tap_clk8");

        // External clock, rising then falling
        wr_reg(A_TCNT, 8'h00);
        wr_reg(A_ICCR, 8'h07);
        for (int i = 0; i < 2; i++) begin
            t_in = 1'b1; repeat (4) step();
            t_in = 1'b0; repeat (4) step();
        end
        wr_reg(A_ICCR, 8'h00);
        rd_chk(A_TCNT, 8'h02, "t_rise");
        wr_reg(A_TCNT, 8'h00);
        wr_reg(A_ICCR, 8'h06);
        for (int i = 0; i < 2; i++) begin
            t_in = 1'b1; repeat (4) step();
            t_in = 1'b0; repeat (4) step();
        end
        t_in = 1'b1; repeat (5) step();
        wr_reg(A_ICCR, 8'h00);
        t_in = 1'b0;
        rd_chk(A_TCNT, 8'h02, "t_fall");

        // ICNC readback depends on build option
        wr_reg(A_ICCR, 8'hC0);
        rd_chk(A_ICCR, ICCR_RB, "iccr_icnc");
        wr_reg(A_ICCR, 8'h00);

`ifdef ATMEGA_TIM_ICP_NOISE_CANCELER_EN
        // Canceler: 3-cycle glitch rejected, 4-cycle pulse captured
        wr_reg(A_TCNT, 8'h33);
        wr_reg(A_ICCR, 8'h80);
        icp = 1'b0; repeat (3) step(); icp = 1'b1;
        repeat (8) step();
        rd_chk(A_TIFR, 8'h00, "glitch_reject");
        icp = 1'b0;
        repeat (4) rd_chk(A_TIFR, 8'h00, "pulse_lat");
        icp = 1'b1;
        repeat (3) rd_chk(A_TIFR, 8'h00, "pulse_lat");
        rd_chk(A_TIFR, 8'h20, "pulse_cap");
        rd_chk(A_ICR, 8'h33, "pulse_icr");
        repeat (8) step();
        wr_reg(A_TIFR, 8'h20);
        wr_reg(A_ICCR, 8'h00);
`endif

        // Capture coincident with TIFR clear: set wins; second capture overwrites
        wr_reg(A_ICCR, 8'h40);
        icp = 1'b0; repeat (5) step();
        wr_reg(A_TCNT, 8'h11);
        icp = 1'b1; step(); step();
        wr_reg(A_TIFR, 8'h20);
        rd_chk(A_TIFR, 8'h20, "set_wins");
        icp = 1'b0; repeat (5) step();
        wr_reg(A_TCNT, 8'h22);
        icp = 1'b1; repeat (4) step();
        rd_chk(A_ICR, 8'h22, "overwrite_icr");
        rd_chk(A_TIFR, 8'h20, "overwrite_flag");

        // Stopped counter capture
        wr_reg(A_TIFR, 8'hFF);
        wr_reg(A_TCNT, 8'h55);
        icp = 1'b0; repeat (5) step();
        icp = 1'b1; repeat (100) step();
        rd_chk(A_ICR, 8'h55, "stopped_icr");
        rd_chk(A_TCNT, 8'h55, "stopped_tcnt");
        rd_chk(A_TIFR, 8'h20, "stopped_icf");
        wr_reg(A_ICR, 8'h99);
        rd_chk(A_ICR, 8'h55, "icr_readonly");
        bus_chk(A_ICR, 1'b0, 8'h00, "rd_low");

        // Reset mid-filter, between clock edges
        wr_reg(A_TIMSK, 8'h21);
        irq_chk(2'b10, "pre_reset_irq");
        wr_reg(A_ICCR, ICNC_VAL | 8'h40);
        icp = 1'b0; repeat (3) step();
        rst = 1'b1;
        bus_chk(A_TIMSK, 1'b1, 8'h00, "midrst_bus");
        irq_chk(2'b00, "midrst_irq");
        rst = 1'b0;
        rd_chk(A_TIFR,  8'h00, "postrst_tifr");
        rd_chk(A_TIMSK, 8'h00, "postrst_timsk");
        rd_chk(A_ICCR,  8'h00, "postrst_iccr");
        wr_reg(A_ICCR, ICNC_VAL);
        icp = 1'b1; repeat (10) step();
        icp = 1'b0;
        lat_chk(CAP_LAT, "postrst_latency");
        rd_chk(A_ICR, 8'h00, "postrst_icr");

        repeat (2) step();
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/atmega_tim_icp_8bit.md
# atmega_tim_icp_8bit

8-bit ATmega-style timer input-capture unit: measures external waveforms (e.g. PWM produced by timer compare outputs) by timestamping edges on an input pin. A free-running 8-bit counter is copied into a capture register on each qualified edge of `icp_i`. Capture and overflow flags are raised for the interrupt controller. The block sits on the same IO register bus and prescaler taps as the other timers.

## Interface
Parameters:
- `BUS_ADDR_DATA_LEN`, 8: IO address width.
- `ICCR_ADDR`, 'h81: control register. Bits: [2:0] CS, [6] ICES, [7] ICNC.
- `TCNT_ADDR`, 'h84: counter register, read/write.
- `ICR_ADDR`, 'h86: capture register, read-only.
- `TIMSK_ADDR`, 'h6F: mask register. Bits: [0] TOIE, [5] ICIE.
- `TIFR_ADDR`, 'h36: flag register. Bits: [0] TOV, [5] ICF.

Ports:
- `clk_i` in 1: IO core clock, the only clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `clk8_i`, `clk64_i`, `clk256_i`, `clk1024_i` in 1 each: prescaler taps, synchronous to `clk_i`.
- `addr_i` in `BUS_ADDR_DATA_LEN`: register address.
- `wr_i`, `rd_i` in 1: write and read strobes.
- `bus_i` in 8: write data.
- `bus_o` out 8: read data (combinational).
- `icp_i` in 1: asynchronous capture pin.
- `t_i` in 1: asynchronous external count clock.
- `icp_int_o`, `tov_int_o` out 1: interrupt requests.
- `icp_int_ack_i`, `tov_int_ack_i` in 1: interrupt acknowledges.

## Operation
- Reset clears every register, synchroniser and filter stage. `bus_o` and both interrupt outputs are 0 during and after reset.
- Count enable `tick` (one `clk_i` cycle) is selected by CS:
  - 000: stopped.
  - 001: every cycle.
  - 010–101: rising edge of the selected tap.
  - 110: falling edge of synchronised `t_i`.
  - 111: rising edge of synchronised `t_i`.
- On `tick`, TCNT increments with 8-bit wrap. On the transition FF→00, TOV is set.
- `icp_i` passes through a 2-FF synchroniser, then the optional noise canceler, then an edge detector. ICES=1 selects rising edges; ICES=0 selects falling edges.
- On a qualified edge: ICR <= TCNT (value before any same-cycle increment) and ICF is set.
- A capture while ICF is already set overwrites ICR. No overrun indication.
- Captures work with the counter stopped; ICR then receives the static TCNT.
- Interrupt outputs: `icp_int_o = ICF & ICIE` and `tov_int_o = TOV & TOIE`. Flags are set regardless of the mask.
- Flags clear on the corresponding ack, or on a TIFR write with a 1 in that bit position.
- Simultaneous set and clear of the same flag: set wins.
- TCNT bus write has priority over increment. A write of FF followed by a tick sets TOV.
- Writes to ICR are ignored. Reads of unmapped addresses, or with `rd_i`=0, return 00.
- Changing ICES does not itself generate a capture. The edge detector compares only successive filtered values.

## Timing
- Capture latency, canceler off: edge on `icp_i` before clk edge 0 → ICR and ICF visible after clk edge 3.
  - Edges 1–2: synchroniser.
  - Edge 3: detect and capture.
- Canceler on: filtered level changes only after 4 consecutive equal synchronised samples. Latency is 3 + 4 = 7 cycles. Pulses of 3 cycles or fewer are rejected.
- Interrupt outputs follow flags combinationally; no extra cycle.
- Ack or TIFR write clears the flag at the next clk edge.
- `t_i` edge to tick: 3 cycles (synchroniser + edge detect).
- Register writes take effect at the next clk edge. New CS or ICES applies from the following cycle.

## Configuration
- `ATMEGA_TIM_ICP_NOISE_CANCELER_EN` defined: the 4-sample canceler is present and ICNC (ICCR[7]) is read/write; ICNC=1 enables filtering.
- Not defined: no filter logic; ICNC is hard-wired 0, writes are ignored, and it reads 0. Latency is always 3 cycles.

## Structure
- Shared package `atmega_tim_pkg`:
  - bit-position constants for CS, ICES, ICNC, TOIE, ICIE, TOV, ICF;
  - CS encoding constants.
- Sub-module `atmega_icp_edge_filter`:
  - function: synchroniser, optional canceler, edge-select detector;
  - output: one-cycle `cap_stb`;
  - reused for `t_i` edge generation with the canceler disabled.
- Top level holds the register file, tick mux, counter and flag logic.

## Test plan
- CS=001, ICES=1, TCNT written 10. Raise `icp_i` → after 3 cycles ICR=0x0C (TCNT at capture cycle), ICF=1, and `icp_int_o`=1 once ICIE=1.
- CS=001, TCNT=FE, TOIE=1 → TOV set after 2 ticks and `tov_int_o`=1. Pulse `tov_int_ack_i` → both 0 next cycle.
- Canceler on, ICES=0. 3-cycle low glitch → no capture. 4-cycle low pulse → capture, 7 cycles after the falling edge.
- Capture strobe in the same cycle as a TIFR write of 0x20 → ICF stays 1. Two captures without clearing → ICR holds the second value.
- CS=000 with TCNT=0x55, edge on `icp_i` → ICR=0x55, and TCNT unchanged for 100 cycles.
- Assert `rst_i` mid-canceler count and between clk edges → all outputs 0 immediately. After release, the first edge needs the full latency.
